// File: rtl/ir_pkg.sv
// Shared types and field layout for the IR command controller.
package ir_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_CHECK = 2'd2,
    ST_PUSH  = 2'd3
  } ir_state_e;

  // One queued key: repeat flag plus the 8-bit key code.
  typedef struct packed {
    logic       rpt;
    logic [7:0] code;
  } ir_key_t;

  // Bit positions of the four bytes inside the LSB-first NEC word.
  localparam int ADDR_LSB  = 0;
  localparam int NADDR_LSB = 8;
  localparam int KEY_LSB   = 16;
  localparam int NKEY_LSB  = 24;

  // Extract one byte of the command word starting at bit lsb.
  function automatic logic [7:0] cmd_field(input logic [31:0] cmd, input int lsb);
    return cmd[lsb +: 8];
  endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// Small show-ahead FIFO of ir_key_t entries; pointers carry an extra wrap bit.
module ir_key_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  ir_key_t din,
  output ir_key_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  ir_key_t     mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Status flags and pointer advance; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ir_command_ctrl.sv
// IR receive sequencing: decoder enable tick, frame detection, NEC validation,
// repeat classification and a key FIFO with valid/ready read-out.
module ir_command_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned PRESCALE      = 1,
  parameter logic [7:0]  ADDR          = 8'h00,
  parameter bit          CHECK_ADDR    = 1'b1,
  parameter logic [31:0] REPEAT_CYCLES = 32'd6_000_000,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_input,
  output logic        dec_enable,
  input  logic        dec_ready,
  input  logic [31:0] dec_command,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_repeat,
  input  logic        key_ready,
  output logic [7:0]  err_count,
  output logic        overflow,
  input  logic        stat_clr
);

  localparam logic [15:0] PRE_RELOAD = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic        dec_enable_q, dec_enable_d;
  logic [2:0]  ir_sync_q, ir_sync_d;
  logic        rdy_q, rdy_d;
  logic        frame_seen_q, frame_seen_d;
  ir_state_e   state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [7:0]  last_key_q, last_key_d;
  logic [31:0] win_cnt_q, win_cnt_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        overflow_q, overflow_d;

  logic        ir_edge, ready_rise, accept, frame_ok, is_repeat;
  logic        err_inc, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  rx_key;
  ir_key_t     fifo_din, fifo_dout;

  // Prescaler: reload on zero and emit a one-cycle enable pulse.
  always_comb begin
    pre_cnt_d    = pre_cnt_q - 16'd1;
    dec_enable_d = 1'b0;
    if (pre_cnt_q == 16'd0) begin
      pre_cnt_d    = PRE_RELOAD;
      dec_enable_d = 1'b1;
    end
  end

  // Input synchronizer, ready edge detect and frame activity tracking.
  always_comb begin
    ir_sync_d    = {ir_sync_q[1:0], ir_input};
    ir_edge      = ir_sync_q[1] ^ ir_sync_q[2];
    rdy_d        = dec_ready;
    ready_rise   = dec_ready && !rdy_q;
    accept       = ready_rise && frame_seen_q && (state_q == ST_IDLE || state_q == ST_RX);
    // A same-cycle edge wins so new activity is credited to the next frame.
    frame_seen_d = ir_edge || (frame_seen_q && !accept);
    cmd_d        = accept ? dec_command : cmd_q;
  end

  // Frame validation and repeat classification on the captured word.
  always_comb begin
    rx_key   = cmd_field(cmd_q, KEY_LSB);
    frame_ok = (cmd_field(cmd_q, NADDR_LSB) == ~cmd_field(cmd_q, ADDR_LSB)) &&
               (cmd_field(cmd_q, NKEY_LSB)  == ~rx_key) &&
               (!CHECK_ADDR || cmd_field(cmd_q, ADDR_LSB) == ADDR);
    is_repeat     = (rx_key == last_key_q) && (win_cnt_q < REPEAT_CYCLES);
    fifo_din.rpt  = is_repeat;
    fifo_din.code = rx_key;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    err_inc   = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CHECK;
        end else if (frame_seen_q) begin
          state_d = ST_RX;
        end
      end
      ST_RX: begin
        if (accept) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          state_d = ST_PUSH;
        end else begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Last-key record, repeat window and status counters; dropped pushes still refresh the record.
  always_comb begin
    fifo_pop    = key_ready && !fifo_empty;
    last_key_d  = last_key_q;
    win_cnt_d   = (win_cnt_q < REPEAT_CYCLES) ? win_cnt_q + 32'd1 : win_cnt_q;
    err_count_d = err_count_q;
    overflow_d  = overflow_q;
    if (fifo_push) begin
      last_key_d = rx_key;
      win_cnt_d  = 32'd0;
    end
    if (stat_clr) begin
      err_count_d = 8'd0;
      overflow_d  = 1'b0;
    end else begin
      if (err_inc && err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers; the window counter starts saturated so the first frame is never a repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q    <= PRE_RELOAD;
      dec_enable_q <= 1'b0;
      ir_sync_q    <= '0;
      rdy_q        <= 1'b0;
      frame_seen_q <= 1'b0;
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      last_key_q   <= '0;
      win_cnt_q    <= REPEAT_CYCLES;
      err_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      dec_enable_q <= dec_enable_d;
      ir_sync_q    <= ir_sync_d;
      rdy_q        <= rdy_d;
      frame_seen_q <= frame_seen_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_key_q   <= last_key_d;
      win_cnt_q    <= win_cnt_d;
      err_count_q  <= err_count_d;
      overflow_q   <= overflow_d;
    end
  end

  ir_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero while the FIFO is empty.
  assign dec_enable = dec_enable_q;
  assign key_valid  = !fifo_empty;
  assign key_code   = fifo_empty ? 8'h00 : fifo_dout.code;
  assign key_repeat = !fifo_empty && fifo_dout.rpt;
  assign err_count  = err_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ir_command_ctrl.sv
// Directed bench for ir_command_ctrl with an expected-key scoreboard.
module tb_ir_command_ctrl;

  localparam int REPEAT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_input;
  logic        dec_enable;
  logic        dec_ready;
  logic [31:0] dec_command;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_repeat;
  logic        key_ready;
  logic [7:0]  err_count;
  logic        overflow;
  logic        stat_clr;

  int vec_cnt     = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  ir_command_ctrl #(
    .PRESCALE      (3),
    .ADDR          (8'h00),
    .CHECK_ADDR    (1'b1),
    .REPEAT_CYCLES (32'd200),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ir_input    (ir_input),
    .dec_enable  (dec_enable),
    .dec_ready   (dec_ready),
    .dec_command (dec_command),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_repeat  (key_repeat),
    .key_ready   (key_ready),
    .err_count   (err_count),
    .overflow    (overflow),
    .stat_clr    (stat_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nec(input logic [7:0] addr, input logic [7:0] key);
    return {~key, key, ~addr, addr};
  endfunction

  // Line activity then a ready rise; returns in the rise cycle (N).
  task automatic start_frame(input logic [31:0] cmd);
    dec_ready = 1'b0;
    ir_input  = ~ir_input;
    tick(2);
    ir_input  = ~ir_input;
    tick(6);
    dec_command = cmd;
    dec_ready   = 1'b1;
  endtask

  // Wait (bounded) for a head entry, compare against the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    logic [31:0] exp;
    int w;
    w = 0;
    while (!key_valid && w < 20) begin
      tick(1);
      w++;
    end
    check({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
    exp = (exp_q.size() != 0) ? {23'd0, exp_q.pop_front()} : 32'hDEAD_BEEF;
    check({tag, "_entry"}, {23'd0, key_repeat, key_code}, exp);
    $display("pop %s: code=%02h repeat=%0d", tag, key_code, key_repeat);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ir_input = 1'b0; dec_ready = 1'b0; dec_command = '0;
    key_ready = 1'b0; stat_clr = 1'b0;
    tick(3);
    check("rst_dec_enable", {31'd0, dec_enable}, 32'd0);
    check("rst_key_valid",  {31'd0, key_valid},  32'd0);
    check("rst_key_code",   {24'd0, key_code},   32'd0);
    check("rst_key_repeat", {31'd0, key_repeat}, 32'd0);
    check("rst_err_count",  {24'd0, err_count},  32'd0);
    check("rst_overflow",   {31'd0, overflow},   32'd0);
    rst = 1'b0;

    // Prescaler: first tick 3 cycles after release, then one in every 3.
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check($sformatf("prescale_%0d", i), {31'd0, dec_enable}, (i % 3 == 0) ? 32'd1 : 32'd0);
    end

    // Idle ready rise with no line activity is ignored.
    dec_command = nec(8'h00, 8'h1A);
    dec_ready   = 1'b1;
    tick(8);
    check("idle_no_key", {31'd0, key_valid}, 32'd0);
    check("idle_no_err", {24'd0, err_count}, 32'd0);

    // Valid frame and its latency.
    start_frame(32'hE51A_FF00);
    exp_q.push_back({1'b0, 8'h1A});
    tick(2);
    check("lat_n2_valid", {31'd0, key_valid}, 32'd0);
    tick(1);
    check("lat_n3_valid",  {31'd0, key_valid},  32'd1);
    check("lat_n3_code",   {24'd0, key_code},   32'h1A);
    check("lat_n3_repeat", {31'd0, key_repeat}, 32'd0);
    check("lat_n3_err",    {24'd0, err_count},  32'd0);
    tick(3);
    check("hold_code", {24'd0, key_code}, 32'h1A);
    pop_check("first");
    check("empty_after_pop", {31'd0, key_valid}, 32'd0);

    // Repeat window.
    start_frame(32'hE51A_FF00);
    exp_q.push_back({1'b1, 8'h1A});
    tick(3);
    pop_check("rep_inside");
    tick(REPEAT + 50);
    start_frame(32'hE51A_FF00);
    exp_q.push_back({1'b0, 8'h1A});
    tick(3);
    pop_check("rep_outside");

    // Rejected frames and status clear.
    start_frame(32'hE51B_FF00);
    tick(5);
    check("bad_inv_err",   {24'd0, err_count}, 32'd1);
    check("bad_inv_nokey", {31'd0, key_valid}, 32'd0);
    start_frame(32'hE51A_FE01);
    tick(5);
    check("bad_addr_err",   {24'd0, err_count}, 32'd2);
    check("bad_addr_nokey", {31'd0, key_valid}, 32'd0);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("stat_clr_err", {24'd0, err_count}, 32'd0);

    // Overflow: five frames into four slots with no consumer.
    for (int k = 0; k < 5; k++) begin
      start_frame(nec(8'h00, 8'(8'h10 + k)));
      if (k < 4) exp_q.push_back({1'b0, 8'(8'h10 + k)});
      tick(4);
    end
    check("ovf_flag", {31'd0, overflow},  32'd1);
    check("ovf_head", {24'd0, key_code},  32'h10);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with push and pop in the same cycle.
    start_frame(nec(8'h00, 8'h15));
    tick(2);
    check("pp_valid", {31'd0, key_valid}, 32'd1);
    check("pp_entry", {23'd0, key_repeat, key_code},
          (exp_q.size() != 0) ? {23'd0, exp_q.pop_front()} : 32'hDEAD_BEEF);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h15});
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("drain_%0d", k));
    check("drained", {31'd0, key_valid}, 32'd0);

    // Reset mid-frame discards queued keys and the partial frame.
    start_frame(32'hE51B_FF00);
    tick(5);
    start_frame(nec(8'h00, 8'h22));
    tick(4);
    check("pre_rst_valid", {31'd0, key_valid}, 32'd1);
    check("pre_rst_err",   {24'd0, err_count}, 32'd1);
    dec_ready = 1'b0;
    ir_input  = ~ir_input;
    tick(2);
    ir_input  = ~ir_input;
    tick(6);
    rst = 1'b1;
    #2;
    check("mid_rst_valid",  {31'd0, key_valid},  32'd0);
    check("mid_rst_code",   {24'd0, key_code},   32'd0);
    check("mid_rst_repeat", {31'd0, key_repeat}, 32'd0);
    check("mid_rst_enable", {31'd0, dec_enable}, 32'd0);
    check("mid_rst_err",    {24'd0, err_count},  32'd0);
    check("mid_rst_ovf",    {31'd0, overflow},   32'd0);
    tick(2);
    rst = 1'b0;
    dec_command = nec(8'h00, 8'h22);
    dec_ready   = 1'b1;
    tick(8);
    check("post_rst_nokey", {31'd0, key_valid}, 32'd0);
    check("post_rst_noerr", {24'd0, err_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_command_ctrl.md
# ir_command_ctrl

Sequencing and dispatch controller for the IR receive path. It drives the decoder's `enable` tick and detects end-of-frame from the decoder's `ready` level. It validates the captured 32-bit NEC-style word (address/inverse checks), classifies key repeats, and queues accepted key codes in a small FIFO. Consumers read the FIFO over a valid/ready handshake. The block sits between the IR decoder and the control logic (menu/LED/register writers).

## Interface

**Parameters**

- `PRESCALE`, default 1: `clk` cycles per `dec_enable` pulse (1..65535). With 1, `dec_enable` is constantly high after reset.
- `ADDR`, default 8'h00: expected device address.
- `CHECK_ADDR`, default 1: 1 rejects frames whose address ≠ `ADDR`.
- `REPEAT_CYCLES`, default 6_000_000: repeat window in `clk` cycles, 32-bit.
- `FIFO_DEPTH`, default 4: key FIFO entries; must be a power of 2, ≥2.

**Ports**

- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `ir_input`, in, 1: raw IR line, the same net that feeds the decoder.
- `dec_enable`, out, 1: decoder enable tick.
- `dec_ready`, in, 1: decoder idle/frame-complete level.
- `dec_command`, in, 32: decoder word, LSB-first. [7:0] address, [15:8] ~address, [23:16] key, [31:24] ~key.
- `key_valid`, out, 1: FIFO head is valid.
- `key_code`, out, 8: head key code.
- `key_repeat`, out, 1: head entry is a repeat.
- `key_ready`, in, 1: consumer accepts the head.
- `err_count`, out, 8: saturating count of rejected frames.
- `overflow`, out, 1: sticky flag; a valid frame was dropped because the FIFO was full.
- `stat_clr`, in, 1: synchronous clear of `err_count` and `overflow`.

## Operation

- **Prescaler:** 16-bit down-counter. `dec_enable` pulses for 1 cycle every `PRESCALE` cycles.
- **Input sync:** `ir_input` passes through a 2-flop synchronizer. An edge is any change between sync stages 2 and 3.
- **Frame detection:**
  - `frame_seen` sets on any synced edge.
  - A `dec_ready` rising edge (registered compare) while `frame_seen`=1 starts checking and clears `frame_seen`.
  - A `dec_ready` rise with `frame_seen`=0 is ignored. This covers the first idle timeout after reset, when the command word is stale or undefined.
- **FSM states:**
  - IDLE → RX on `frame_seen`.
  - RX → CHECK on `dec_ready` rise.
  - CHECK → PUSH if valid, else → IDLE with `err_count`+1.
  - PUSH → IDLE.
- **Validity, evaluated in CHECK:**
  - [15:8] == ~[7:0]
  - [31:24] == ~[23:16]
  - if `CHECK_ADDR`=1: [7:0] == `ADDR`
- **Repeat classification:**
  - A 32-bit counter restarts at 0 on every accepted frame and saturates at `REPEAT_CYCLES`.
  - A frame is a repeat if the key equals the last accepted key and the counter < `REPEAT_CYCLES`.
  - The first frame after reset is never a repeat.
- **PUSH:**
  - Writes {repeat, key} to the FIFO.
  - If the FIFO is full and no pop happens this cycle: drop the frame and set `overflow`. The last-key record and window counter still update.
- **Consumer handshake:** `key_valid`/`key_code`/`key_repeat` hold steady until a cycle where `key_valid`&&`key_ready`.
- **Status:** `err_count` saturates at 255. `stat_clr` wins over a same-cycle increment or set.

## Timing

- **Reset values:** `dec_enable`=0, `key_valid`=0, `key_code`=0, `key_repeat`=0, `err_count`=0, `overflow`=0. FSM in IDLE, FIFO empty, `frame_seen`=0, window counter saturated.
- **First tick after reset:** `dec_enable` first goes high `PRESCALE` cycles after reset release.
- **Latency:** with `dec_ready` rising in cycle N, CHECK is in N+1, PUSH in N+2, and `key_valid` is high in N+3 (empty FIFO case).
- **FIFO:** show-ahead.
  - A pop in cycle M presents the next entry in M+1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop in the same cycle when empty: the push lands and `key_valid` rises next cycle.
- **Same-cycle edge and ready rise:** a synced edge in the same cycle as the `dec_ready` rise re-sets `frame_seen`, so the new activity belongs to the next frame.
- **Reset mid-operation:** all state clears, any partial frame is discarded, and queued keys are lost.

## Structure

- **Package `ir_pkg`:**
  - FSM state enum (IDLE, RX, CHECK, PUSH).
  - FIFO entry typedef `ir_key_t` {repeat, code[7:0]}.
  - Field index constants for address, ~address, key and ~key.
- **Sub-module `ir_key_fifo`:** parameterized synchronous FIFO (`DEPTH`, entry type `ir_key_t`).
  - Ports: push, pop, full, empty.
  - Write and read pointers are log2(`DEPTH`)+1 bits wide; full/empty are derived from the extra wrap bit.

## Test plan

- **Valid frame:** `dec_command`=32'hE51A_FF00 (address 00, key 1A), edges on `ir_input`, then `dec_ready` rises. Expect `key_valid` 3 cycles later, `key_code`=8'h1A, `key_repeat`=0, `err_count`=0.
- **Repeat window:** same frame again within `REPEAT_CYCLES` → `key_repeat`=1. Same frame after the window expires → `key_repeat`=0.
- **Rejected frames:** bad inverse 32'hE51B_FF00 → no push, `err_count`=1. Address 8'h01 with `CHECK_ADDR`=1 → `err_count`=2. Pulse `stat_clr` → `err_count`=0.
- **Idle ready ignored:** `dec_ready` rises after reset with no `ir_input` activity → no push, no error.
- **Overflow:** `key_ready`=0 while 5 valid frames arrive (`FIFO_DEPTH`=4) → 4 entries held, `overflow`=1, entries pop in order. Full FIFO with push and pop in the same cycle → no overflow.
- **Reset and prescaler:** assert `rst` in the RX state mid-frame → all outputs at reset values and no key delivered. With `PRESCALE`=3, `dec_enable` is high exactly 1 cycle in every 3.
